// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multi-cycle CPU control unit:
// FSM states, opcodes, write-back/PC source selects and the decoded control bundle.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_FAULT
  } state_t;

  localparam logic [4:0] OP_MV    = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_CMP   = 5'b00011;
  localparam logic [4:0] OP_LD    = 5'b00100;
  localparam logic [4:0] OP_ST    = 5'b00101;
  localparam logic [4:0] OP_JR    = 5'b01000;
  localparam logic [4:0] OP_JZR   = 5'b01001;
  localparam logic [4:0] OP_JNR   = 5'b01010;
  localparam logic [4:0] OP_CALLR = 5'b01100;
  localparam logic [4:0] OP_MVI   = 5'b10000;
  localparam logic [4:0] OP_ADDI  = 5'b10001;
  localparam logic [4:0] OP_SUBI  = 5'b10010;
  localparam logic [4:0] OP_CMPI  = 5'b10011;
  localparam logic [4:0] OP_MVHI  = 5'b10110;
  localparam logic [4:0] OP_J     = 5'b11000;
  localparam logic [4:0] OP_JZ    = 5'b11001;
  localparam logic [4:0] OP_JN    = 5'b11010;
  localparam logic [4:0] OP_CALL  = 5'b11100;

  localparam logic [2:0] WB_MEM  = 3'b000;
  localparam logic [2:0] WB_ALU  = 3'b001;
  localparam logic [2:0] WB_PC2  = 3'b010;
  localparam logic [2:0] WB_RY   = 3'b011;
  localparam logic [2:0] WB_IMM8 = 3'b100;
  localparam logic [2:0] WB_HI   = 3'b101;

  localparam logic [1:0] PC_IMM = 2'b00;
  localparam logic [1:0] PC_RY  = 2'b01;
  localparam logic [1:0] PC_INC = 2'b10;

  // pc_src holds the taken target; cond_z/cond_n make it conditional on the flags.
  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       alu_op;
    logic       alu_src;
    logic       ext_sel;
    logic [2:0] wb_src;
    logic [1:0] pc_src;
    logic       nz;
    logic       mem_access;
    logic       mem_write;
    logic       cond_z;
    logic       cond_n;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Handshake/control bundle between the control FSM (master) and the datapath/memory side (slave).
interface multicycle_control_fsm_if #(
  parameter int OPCODE_W = 5
);
  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                flag_n;
  logic                flag_z;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_sel;
  logic                ir_load;
  logic                MemWrite;
  logic                RegWrite;
  logic                RegDst;
  logic                ALUOp;
  logic                ALUSrc;
  logic                ExtSel;
  logic [2:0]          WBSrc;
  logic [1:0]          PCSrc;
  logic                NZ;
  logic                pc_enable;
  logic                busy;
  logic                fault;

  modport master (
    input  run, opcode, flag_n, flag_z, mem_ready,
    output mem_req, mem_sel, ir_load, MemWrite, RegWrite, RegDst, ALUOp, ALUSrc,
           ExtSel, WBSrc, PCSrc, NZ, pc_enable, busy, fault
  );

  modport slave (
    output run, opcode, flag_n, flag_z, mem_ready,
    input  mem_req, mem_sel, ir_load, MemWrite, RegWrite, RegDst, ALUOp, ALUSrc,
           ExtSel, WBSrc, PCSrc, NZ, pc_enable, busy, fault
  );
endinterface

// File: rtl/multicycle_control_fsm_isa_decode.sv
// Combinational opcode decoder: maps the instruction opcode to a control bundle and
// flags anything outside the ISA (including calls when they are disabled) as illegal.
module isa_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 5,
  parameter int ENABLE_CALL = 1
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                illegal
);

  logic [4:0] w_op;
  logic       w_upper_nz;

  assign w_op = opcode[4:0];

  generate
    if (OPCODE_W > 5) begin : g_upper
      assign w_upper_nz = |opcode[OPCODE_W-1:5];
    end else begin : g_no_upper
      assign w_upper_nz = 1'b0;
    end
  endgenerate

  always_comb begin
    ctrl        = '0;
    ctrl.wb_src = WB_ALU;
    ctrl.pc_src = PC_INC;
    illegal     = 1'b0;
    case (w_op)
      OP_MV:   begin ctrl.reg_write = 1'b1; ctrl.wb_src = WB_RY; end
      OP_ADD:  begin ctrl.reg_write = 1'b1; ctrl.nz = 1'b1; end
      OP_SUB:  begin ctrl.reg_write = 1'b1; ctrl.nz = 1'b1; ctrl.alu_op = 1'b1; end
      OP_CMP:  begin ctrl.nz = 1'b1; ctrl.alu_op = 1'b1; end
      OP_LD:   begin ctrl.reg_write = 1'b1; ctrl.wb_src = WB_MEM; ctrl.mem_access = 1'b1; end
      OP_ST:   begin ctrl.mem_access = 1'b1; ctrl.mem_write = 1'b1; end
      OP_MVI:  begin ctrl.reg_write = 1'b1; ctrl.wb_src = WB_IMM8; end
      OP_ADDI: begin ctrl.reg_write = 1'b1; ctrl.nz = 1'b1; ctrl.alu_src = 1'b1; end
      OP_SUBI: begin
        ctrl.reg_write = 1'b1; ctrl.nz = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = 1'b1;
      end
      OP_CMPI: begin ctrl.nz = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = 1'b1; end
      OP_MVHI: begin ctrl.reg_write = 1'b1; ctrl.wb_src = WB_HI; end
      OP_JR:   ctrl.pc_src = PC_RY;
      OP_JZR:  begin ctrl.pc_src = PC_RY; ctrl.cond_z = 1'b1; end
      OP_JNR:  begin ctrl.pc_src = PC_RY; ctrl.cond_n = 1'b1; end
      OP_J:    begin ctrl.pc_src = PC_IMM; ctrl.ext_sel = 1'b1; end
      OP_JZ:   begin ctrl.pc_src = PC_IMM; ctrl.ext_sel = 1'b1; ctrl.cond_z = 1'b1; end
      OP_JN:   begin ctrl.pc_src = PC_IMM; ctrl.ext_sel = 1'b1; ctrl.cond_n = 1'b1; end
      OP_CALL: begin
        ctrl.pc_src = PC_IMM; ctrl.ext_sel = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.reg_dst = 1'b1;  ctrl.wb_src = WB_PC2;
        if (ENABLE_CALL == 0) illegal = 1'b1;
      end
      OP_CALLR: begin
        ctrl.pc_src = PC_RY; ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.wb_src = WB_PC2;
        if (ENABLE_CALL == 0) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (w_upper_nz) illegal = 1'b1;
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory-wait timeout,
// flag-conditional branches and a terminal FAULT state left only through reset.
module multicycle_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int ENABLE_CALL = 1
) (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_fsm_if.master bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  ctrl_t            w_ctrl;
  logic             w_illegal;
  logic             w_taken;

  isa_decode #(
    .OPCODE_W   (OPCODE_W),
    .ENABLE_CALL(ENABLE_CALL)
  ) u_decode (
    .opcode (bus.opcode),
    .ctrl   (w_ctrl),
    .illegal(w_illegal)
  );

  assign w_taken = (!w_ctrl.cond_z || bus.flag_z) && (!w_ctrl.cond_n || bus.flag_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Every control falls back to its idle value unless the current state uses it.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    bus.mem_req   = 1'b0;
    bus.mem_sel   = 1'b0;
    bus.ir_load   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.RegDst    = 1'b0;
    bus.ALUOp     = 1'b0;
    bus.ALUSrc    = 1'b0;
    bus.ExtSel    = 1'b0;
    bus.WBSrc     = WB_ALU;
    bus.PCSrc     = PC_INC;
    bus.NZ        = 1'b0;
    bus.pc_enable = 1'b0;
    bus.busy      = (r_state != S_IDLE) && (r_state != S_FAULT);
    bus.fault     = (r_state == S_FAULT);
    case (r_state)
      S_IDLE: begin
        if (bus.run) begin
          w_state_next = S_FETCH;
          w_cnt_next   = '0;
        end
      end
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.mem_sel = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_load  = 1'b1;
          w_state_next = S_DECODE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_FAULT;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_DECODE: w_state_next = w_illegal ? S_FAULT : S_EXEC;
      S_EXEC: begin
        bus.ALUOp  = w_ctrl.alu_op;
        bus.ALUSrc = w_ctrl.alu_src;
        bus.ExtSel = w_ctrl.ext_sel;
        if (w_ctrl.mem_access) begin
          w_state_next = S_MEM;
          w_cnt_next   = '0;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.MemWrite = w_ctrl.mem_write;
        if (bus.mem_ready) begin
          w_state_next = S_WB;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_FAULT;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_WB: begin
        bus.RegWrite  = w_ctrl.reg_write;
        bus.RegDst    = w_ctrl.reg_dst;
        bus.WBSrc     = w_ctrl.wb_src;
        bus.NZ        = w_ctrl.nz;
        bus.pc_enable = 1'b1;
        bus.ExtSel    = w_ctrl.ext_sel;
        bus.PCSrc     = w_taken ? w_ctrl.pc_src : PC_INC;
        w_state_next  = bus.run ? S_FETCH : S_IDLE;
        w_cnt_next    = '0;
      end
      default: w_state_next = S_FAULT;
    endcase
  end

endmodule
